// File: rtl/simon_pkt_serializer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | simon_pkt_serializer: buffers cipher blocks and streams them as framed    |
// | bytes (seq header, then block bytes MSB first) over a valid/ready link.   |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module simon_pkt_serializer #(
  parameter int N = 16,
  parameter int D = 2
) (
  input  logic              clk,
  input  logic              nR,
  input  logic              donePkt,
  input  logic [1:0][N-1:0] outData,
  output logic [7:0]        outByte,
  output logic              outValid,
  input  logic              outReady,
  output logic              frameLast,
  output logic              busy,
  output logic              overflow
);

  localparam int c_nb = 2 * N / 8;
  localparam int c_pw = $clog2(D);
  localparam int c_cw = c_pw + 1;
  localparam int c_iw = (c_nb > 1) ? $clog2(c_nb) : 1;
  localparam logic [c_cw-1:0] c_depth = c_cw'(D);
  localparam logic [c_iw-1:0] c_last  = c_iw'(c_nb - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t          r_state;
  logic [2*N-1:0]  r_fifo_data [D];
  logic [7:0]      r_fifo_seq  [D];
  logic [c_pw-1:0] r_wr_ptr;
  logic [c_pw-1:0] r_rd_ptr;
  logic [c_cw-1:0] r_count;
  logic [c_iw-1:0] r_idx;
  logic [7:0]      r_seq;

  state_t          w_state_nxt;
  logic            w_xfer;
  logic            w_pop;
  logic            w_push;
  logic [c_cw-1:0] w_count_nxt;
  logic [c_pw-1:0] w_rd_nxt;
  logic [7:0]      w_head_seq;
  logic [c_iw-1:0] w_idx_nxt;
  logic [7:0]      w_byte_nxt;

  function automatic logic [7:0] sel_byte(input logic [2*N-1:0] word, input logic [c_iw-1:0] idx);
    return word[(c_nb - 1 - int'(idx)) * 8 +: 8];
  endfunction

  always_comb begin
    w_xfer      = outValid & outReady;
    w_pop       = w_xfer && (r_state == DATA) && (r_idx == c_last);
    // A full buffer still accepts when its head frame finishes this cycle.
    w_push      = donePkt && ((r_count != c_depth) || w_pop);
    w_count_nxt = r_count + c_cw'(w_push) - c_cw'(w_pop);
    w_rd_nxt    = r_rd_ptr + c_pw'(w_pop);
    // If the buffer drains this cycle, the next head is the block being written now.
    w_head_seq  = (r_count == c_cw'(w_pop)) ? r_seq : r_fifo_seq[w_rd_nxt];

    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_byte_nxt  = outByte;
    case (r_state)
      IDLE: begin
        w_byte_nxt = 8'h00;
        if (w_count_nxt != '0) begin
          w_state_nxt = HDR;
          w_byte_nxt  = w_head_seq;
        end
      end
      HDR: begin
        if (w_xfer) begin
          w_state_nxt = DATA;
          w_idx_nxt   = '0;
          w_byte_nxt  = sel_byte(r_fifo_data[r_rd_ptr], '0);
        end
      end
      DATA: begin
        if (w_xfer) begin
          if (r_idx == c_last) begin
            w_idx_nxt = '0;
            if (w_count_nxt != '0) begin
              w_state_nxt = HDR;
              w_byte_nxt  = w_head_seq;
            end else begin
              w_state_nxt = IDLE;
              w_byte_nxt  = 8'h00;
            end
          end else begin
            w_idx_nxt  = r_idx + 1'b1;
            w_byte_nxt = sel_byte(r_fifo_data[r_rd_ptr], r_idx + 1'b1);
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_idx_nxt   = '0;
        w_byte_nxt  = 8'h00;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_data[r_wr_ptr] <= outData;
      r_fifo_seq[r_wr_ptr]  <= r_seq;
    end
  end

  always_ff @(posedge clk or negedge nR) begin
    if (!nR) begin
      r_state   <= IDLE;
      r_count   <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_idx     <= '0;
      r_seq     <= 8'h00;
      outByte   <= 8'h00;
      outValid  <= 1'b0;
      frameLast <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_count   <= w_count_nxt;
      r_rd_ptr  <= w_rd_nxt;
      r_idx     <= w_idx_nxt;
      outByte   <= w_byte_nxt;
      outValid  <= (w_state_nxt != IDLE);
      frameLast <= (w_state_nxt == DATA) && (w_idx_nxt == c_last);
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
        r_seq    <= r_seq + 8'd1;
      end
      if (donePkt && !w_push) begin
        overflow <= 1'b1;
      end
    end
  end

  assign busy = (r_count != '0) || (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_simon_pkt_serializer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_simon_pkt_serializer: directed self-checking bench for the serializer. |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_simon_pkt_serializer;

  logic             clk;
  logic             nR;
  logic             donePkt;
  logic [1:0][15:0] outData;
  logic [7:0]       outByte;
  logic             outValid;
  logic             outReady;
  logic             frameLast;
  logic             busy;
  logic             overflow;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] got_q[$];
  logic       got_fl[$];
  logic [7:0] exp_q[$];

  simon_pkt_serializer #(.N(16), .D(2)) dut (
    .clk      (clk),
    .nR       (nR),
    .donePkt  (donePkt),
    .outData  (outData),
    .outByte  (outByte),
    .outValid (outValid),
    .outReady (outReady),
    .frameLast(frameLast),
    .busy     (busy),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // All tasks start and end on a falling edge.
  task automatic do_reset();
    nR = 1'b0; donePkt = 1'b0; outReady = 1'b0;
    @(negedge clk);
    nR = 1'b1;
  endtask

  task automatic push_block(input logic [31:0] d);
    donePkt = 1'b1;
    outData = d;
    @(negedge clk);
    donePkt = 1'b0;
  endtask

  task automatic add_exp(input logic [7:0] hdr, input logic [31:0] d);
    logic [31:0] w;
    w = d;
    exp_q.push_back(hdr);
    for (int b = 3; b >= 0; b--) exp_q.push_back(w[b*8 +: 8]);
  endtask

  task automatic collect(input int cycles, input logic [31:0] rmask,
                         input bit inject, input logic [31:0] inj_data);
    logic       held_v;
    logic [7:0] held_b;
    logic       r;
    bit         injd;
    held_v = 1'b0; held_b = 8'h00; injd = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      if (held_v) begin
        check("hold_valid", outValid, 1'b1);
        check("hold_byte", outByte, held_b);
      end
      r = (i < 32) ? rmask[i] : 1'b1;
      outReady = r;
      donePkt  = 1'b0;
      if (inject && !injd && outValid && frameLast && r) begin
        donePkt = 1'b1;
        outData = inj_data;
        injd    = 1'b1;
      end
      if (outValid && r) begin
        got_q.push_back(outByte);
        got_fl.push_back(frameLast);
      end
      held_v = outValid && !r;
      held_b = outByte;
      @(negedge clk);
    end
    donePkt = 1'b0;
  endtask

  task automatic check_frames(input string tag);
    check({tag, "_len"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) check(tag, got_q[i], exp_q[i]);
  endtask

  task automatic clear_q();
    got_q.delete(); got_fl.delete(); exp_q.delete();
  endtask

  initial begin
    nR = 1'b0; donePkt = 1'b0; outReady = 1'b0; outData = '0;
    @(negedge clk);
    check("rst_valid", outValid, 1'b0);
    check("rst_byte", outByte, 8'h00);
    check("rst_last", frameLast, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_ovf", overflow, 1'b0);
    nR = 1'b1;

    // Single block, one-cycle latency to header
    clear_q();
    outReady = 1'b1;
    push_block(32'h6565_6877);
    check("lat_valid", outValid, 1'b1);
    check("lat_hdr", outByte, 8'h00);
    check("lat_busy", busy, 1'b1);
    add_exp(8'h00, 32'h6565_6877);
    collect(5, '1, 1'b0, '0);
    check_frames("single");
    for (int i = 0; i < got_fl.size(); i++) check("single_fl", got_fl[i], (i == 4));
    check("single_end_valid", outValid, 1'b0);
    check("single_end_busy", busy, 1'b0);

    // Backpressure mid-frame: ready pattern 1,1,0,0,0,1,1,1
    clear_q();
    push_block(32'h1234_5678);
    add_exp(8'h01, 32'h1234_5678);
    collect(8, 32'hFFFF_FFE3, 1'b0, '0);
    check_frames("bp");
    check("bp_end_valid", outValid, 1'b0);

    // Overflow: three strobes into a depth-2 buffer with no consumer
    do_reset();
    clear_q();
    outReady = 1'b0;
    donePkt = 1'b1; outData = 32'hAAAA_BBBB;
    @(negedge clk);
    outData = 32'hCCCC_DDDD;
    @(negedge clk);
    outData = 32'hEEEE_FFFF;
    @(negedge clk);
    donePkt = 1'b0;
    check("ovf_flag", overflow, 1'b1);
    check("ovf_hdr", outByte, 8'h00);
    check("ovf_busy", busy, 1'b1);
    add_exp(8'h00, 32'hAAAA_BBBB);
    add_exp(8'h01, 32'hCCCC_DDDD);
    collect(10, '1, 1'b0, '0);
    check_frames("ovf_b2b");
    check("ovf_end_valid", outValid, 1'b0);
    check("ovf_sticky", overflow, 1'b1);

    // Full buffer frees a slot in the same cycle a new block arrives
    do_reset();
    clear_q();
    outReady = 1'b0;
    push_block(32'h0102_0304);
    push_block(32'h0506_0708);
    add_exp(8'h00, 32'h0102_0304);
    add_exp(8'h01, 32'h0506_0708);
    add_exp(8'h02, 32'h090A_0B0C);
    collect(16, '1, 1'b1, 32'h090A_0B0C);
    check_frames("freeacc");
    check("freeacc_ovf", overflow, 1'b0);
    check("freeacc_end_valid", outValid, 1'b0);

    // Sequence number wraps after 256 accepted blocks
    do_reset();
    for (int i = 0; i < 257; i++) begin
      clear_q();
      push_block(32'h0100_0000 + i);
      collect(5, '1, 1'b0, '0);
      check("seq_hdr", (got_q.size() > 0) ? {24'd0, got_q[0]} : 32'hFFFF_FFFF, i & 32'hFF);
    end
    check("seq_ovf", overflow, 1'b0);

    // Asynchronous reset two bytes into a frame
    clear_q();
    push_block(32'hDEAD_BEEF);
    collect(2, '1, 1'b0, '0);
    check("pre_rst_valid", outValid, 1'b1);
    #2 nR = 1'b0;
    #1;
    check("arst_valid", outValid, 1'b0);
    check("arst_byte", outByte, 8'h00);
    check("arst_busy", busy, 1'b0);
    @(negedge clk);
    check("arst_hold_valid", outValid, 1'b0);
    nR = 1'b1;
    clear_q();
    push_block(32'h1357_9BDF);
    check("post_rst_valid", outValid, 1'b1);
    add_exp(8'h00, 32'h1357_9BDF);
    collect(6, '1, 1'b0, '0);
    check_frames("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
